// File: rtl/relm_ps2_rx.sv
// PS/2 keyboard receiver: filters raw PS/2 lines, deframes 11-bit frames, buffers bytes in a register FIFO.
// Latency: raw clk fall to detect ~WF+3 cycles; push 1 cycle after stop detect; byte visible 1 cycle after push.
// Backpressure: the pop port signals retry while empty; bytes arriving while full are dropped and flagged as overflow.
module relm_ps2_rx #(
  parameter int WD  = 32,
  parameter int WAD = 4,
  parameter int WF  = 8,
  parameter int WT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;
  localparam int         DEPTH    = 1 << WAD;
  localparam int         CW       = WAD + 1;
  localparam logic [WT-1:0] TO_MAX = {WT{1'b1}};

  // input conditioning
  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [WF-1:0] clk_flt_q, dat_flt_q;
  logic          clk_lvl_q, clk_lvl_d, dat_lvl_q, dat_lvl_d, clk_prev_q;
  logic          clk_fall, clk_edge;

  // deframer
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          push_q, push_d;
  logic [WT-1:0] to_cnt_q, to_cnt_d;
  logic          timeout, ferr_set;

  // fifo and flags
  logic [7:0]     mem_q [DEPTH];
  logic [WAD-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ferr_q, ferr_d, ovf_q, ovf_d;
  logic           empty, full, do_push, do_pop, ovf_set, flag_clr;
  logic           unused_pop_bits;

  assign unused_pop_bits = ^pop_d[WD-1:1];

  // Filtered levels only move when every sample in the window agrees.
  always_comb begin
    clk_lvl_d = clk_lvl_q;
    dat_lvl_d = dat_lvl_q;
    if (&clk_flt_q)       clk_lvl_d = 1'b1;
    else if (~|clk_flt_q) clk_lvl_d = 1'b0;
    if (&dat_flt_q)       dat_lvl_d = 1'b1;
    else if (~|dat_flt_q) dat_lvl_d = 1'b0;
  end

  // Synchronize raw lines, shift into filter windows, register filtered levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_flt_q  <= {WF{1'b1}};
      dat_flt_q  <= {WF{1'b1}};
      clk_lvl_q  <= 1'b1;
      dat_lvl_q  <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      clk_flt_q  <= {clk_flt_q[WF-2:0], clk_sync_q};
      dat_flt_q  <= {dat_flt_q[WF-2:0], dat_sync_q};
      clk_lvl_q  <= clk_lvl_d;
      dat_lvl_q  <= dat_lvl_d;
      clk_prev_q <= clk_lvl_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_lvl_q;
  assign clk_edge = clk_prev_q ^ clk_lvl_q;
  assign timeout  = (state_q != S_IDLE) && (to_cnt_q == TO_MAX);

  // Deframing FSM; a stalled frame is abandoned by the timeout before any edge is honoured.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    ferr_set  = 1'b0;
    if (timeout) begin
      state_d  = S_IDLE;
      ferr_set = 1'b1;
    end else if (clk_fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_lvl_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
            par_d     = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {dat_lvl_q, shift_q[7:1]};
          par_d     = par_q ^ dat_lvl_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          // accumulator started at 1, so odd parity leaves it at 0
          par_d   = par_q ^ dat_lvl_q;
          state_d = S_STOP;
        end
        default: begin
          if (dat_lvl_q && !par_q) push_d = 1'b1;
          else                     ferr_set = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Inactivity counter restarts on every filtered clk transition and while idle.
  always_comb begin
    if (state_q == S_IDLE || clk_edge || timeout) to_cnt_d = '0;
    else                                          to_cnt_d = to_cnt_q + WT'(1);
  end

  // Deframer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      push_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      push_q    <= push_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign do_pop   = pop_d[WD] & ~empty;
  assign do_push  = push_q & (~full | do_pop);
  assign ovf_set  = push_q & full & ~do_pop;
  assign flag_clr = pop_d[WD] & pop_d[0];

  // FIFO pointer/count and sticky flag next-state; a set in the clear cycle wins.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + WAD'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + WAD'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    ferr_d   = (ferr_q & ~flag_clr) | ferr_set;
    ovf_d    = (ovf_q  & ~flag_clr) | ovf_set;
  end

  // FIFO control and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; shift_q is stable in the push cycle because IDLE leaves it alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  // Show-ahead response: retry while empty, head byte forced to zero when empty.
  always_comb begin
    pop_q      = '0;
    pop_q[WD]  = empty;
    pop_q[9]   = ferr_q;
    pop_q[8]   = ovf_q;
    pop_q[7:0] = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_relm_ps2_rx.sv
module tb_relm_ps2_rx;

  localparam int WD   = 32;
  localparam int WAD  = 4;
  localparam int WF   = 8;
  localparam int WT   = 10;
  localparam int HALF = 20;
  localparam logic [WD:0] EMPTY_RESP = {1'b1, {WD{1'b0}}};

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk_in, ps2_dat_in;
  logic [WD:0] pop_d, pop_q;
  logic        mon_pop, tb_pop, tb_clr, mon_en;
  logic [7:0]  exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  assign pop_d = {mon_pop | tb_pop, {(WD-1){1'b0}}, tb_clr};

  relm_ps2_rx #(.WD(WD), .WAD(WAD), .WF(WF), .WT(WT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .pop_d      (pop_d),
    .pop_q      (pop_q)
  );

  always #5 clk = ~clk;

  function automatic logic [WD:0] resp(input logic retry, input logic err, input logic ovf,
                                        input logic [7:0] b);
    return {retry, {(WD-10){1'b0}}, err, ovf, b};
  endfunction

  task automatic check(input string name, input logic [WD:0] act, input logic [WD:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever a byte is presented and compares it to the scoreboard.
  initial begin
    mon_pop = 1'b0;
    forever begin
      @(negedge clk);
      mon_pop = 1'b0;
      if (mon_en && !rst && pop_q[WD] == 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mon_unexpected: got byte %h, expected no byte", pop_q[7:0]);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("mon_byte", {{(WD-7){1'b0}}, pop_q[7:0]}, {{(WD-7){1'b0}}, e});
        end
        mon_pop = 1'b1;
      end
    end
  end

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one PS/2 frame (or its first nbits bits). Data changes while clk is high.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit pop_at_stop,
                            input bit chk_lat, input int glitch_bit, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2_dat_in = fr[k];
      for (int i = 0; i < HALF; i++) begin
        @(negedge clk);
        if (k == glitch_bit && i == 5) ps2_clk_in = 1'b0;
        if (k == glitch_bit && i == 8) ps2_clk_in = 1'b1;
      end
      ps2_clk_in = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(negedge clk);
        if (k == 10) begin
          if (chk_lat && i == 12) check("lat_pending", {{WD{1'b0}}, pop_q[WD]}, {{WD{1'b0}}, 1'b1});
          if (chk_lat && i == 13) check("lat_visible", pop_q, resp(1'b0, 1'b0, 1'b0, b));
          if (pop_at_stop) tb_pop = (i == 12);
        end
      end
      ps2_clk_in = 1'b1;
    end
    ps2_dat_in = 1'b1;
    if (nbits == 11) repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d bytes still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    tb_pop = 1'b1;
    tb_clr = 1'b1;
    @(negedge clk);
    tb_pop = 1'b0;
    tb_clr = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    tb_pop     = 1'b0;
    tb_clr     = 1'b0;
    mon_en     = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_state", pop_q, EMPTY_RESP);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Valid frame with latency check, then popped back to empty.
    mon_en = 1'b1;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, -1, 11);
    wait_drain("drain_1c");
    check("after_pop_1c", pop_q, EMPTY_RESP);

    // Bad parity: nothing pushed, error flag set, cleared by flagged pop.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, -1, 11);
    check("parity_err", pop_q, resp(1'b1, 1'b1, 1'b0, 8'h00));
    clear_flags();
    check("parity_clear", pop_q, EMPTY_RESP);

    // Overflow: 17 frames with no pops; the 17th is lost.
    mon_en = 1'b0;
    for (int v = 1; v <= 17; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b0, -1, 11);
    check("ovf_full", pop_q, resp(1'b0, 1'b0, 1'b1, 8'h01));
    for (int v = 1; v <= 16; v++) exp_q.push_back(8'(v));
    mon_en = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_drained", pop_q, resp(1'b1, 1'b0, 1'b1, 8'h00));
    clear_flags();
    check("ovf_clear", pop_q, EMPTY_RESP);

    // Short low glitch on the clock line mid-frame is filtered out.
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 4, 11);
    wait_drain("drain_glitch");
    check("glitch_idle", pop_q, EMPTY_RESP);

    // Stalled frame times out into IDLE with a frame error.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1, 4);
    repeat ((1 << WT) - 200) @(negedge clk);
    check("timeout_early", pop_q, EMPTY_RESP);
    repeat (300) @(negedge clk);
    check("timeout_flag", pop_q, resp(1'b1, 1'b1, 1'b0, 8'h00));
    clear_flags();
    check("timeout_clear", pop_q, EMPTY_RESP);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, 11);
    wait_drain("drain_5a");

    // Full FIFO with push and pop in the same cycle: no overflow, new byte last.
    mon_en = 1'b0;
    for (int v = 0; v < 16; v++) send_frame(8'h20 + 8'(v), 1'b0, 1'b0, 1'b0, -1, 11);
    check("full_head", pop_q, resp(1'b0, 1'b0, 1'b0, 8'h20));
    send_frame(8'h30, 1'b0, 1'b1, 1'b0, -1, 11);
    check("simul_head", pop_q, resp(1'b0, 1'b0, 1'b0, 8'h21));
    for (int v = 1; v <= 16; v++) exp_q.push_back(8'h20 + 8'(v));
    mon_en = 1'b1;
    wait_drain("drain_simul");
    check("simul_drained", pop_q, EMPTY_RESP);

    // Reset mid-frame clears everything immediately.
    mon_en = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, -1, 11);
    check("pre_rst", pop_q, resp(1'b0, 1'b0, 1'b0, 8'h33));
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1, 3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_immediate", pop_q, EMPTY_RESP);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    mon_en = 1'b1;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b0, 1'b0, 1'b0, -1, 11);
    wait_drain("drain_post_rst");
    check("post_rst_idle", pop_q, EMPTY_RESP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
